// File: rtl/param_register_file.sv
// rtl/param_register_file.sv - parametrised register file with clear sweep, bypass, busy scoreboard
module param_register_file #(
  parameter int DATA_W      = 16,
  parameter int NUM_REGS    = 8,
  parameter int ADDR_W      = $clog2(NUM_REGS),
  parameter int NUM_RD      = 2,
  parameter bit SPECIAL_EN  = 1'b1,
  parameter int SPECIAL_IDX = NUM_REGS - 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_req,
  output logic                     ready,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wd,
  input  logic [DATA_W-1:0]        ext_special,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     wr_err
);

  localparam logic [ADDR_W-1:0] SPEC_ADDR = ADDR_W'(SPECIAL_IDX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   sweep_cnt;
  logic [NUM_REGS-1:0] busy;
  logic [DATA_W-1:0]   mem [NUM_REGS];

  logic wr_special;
  logic rsv_special;
  logic wr_legal;

  assign wr_special  = SPECIAL_EN && (wr_addr == SPEC_ADDR);
  assign rsv_special = SPECIAL_EN && (rsv_addr == SPEC_ADDR);
  assign wr_legal    = we && !wr_special;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_CLEAR;
      sweep_cnt <= '0;
      busy      <= '0;
      wr_err    <= 1'b0;
      ready     <= 1'b0;
    end else begin
      wr_err <= 1'b0;
      case (state)
        ST_CLEAR: begin
          wr_err <= we;
          if (clear_req) begin
            sweep_cnt <= '0;
          end else if (sweep_cnt == LAST_ADDR) begin
            state     <= ST_READY;
            ready     <= 1'b1;
            sweep_cnt <= '0;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
          end
        end
        ST_READY: begin
          if (clear_req) begin
            state     <= ST_CLEAR;
            ready     <= 1'b0;
            sweep_cnt <= '0;
            busy      <= '0;
          end else begin
            wr_err <= we && wr_special;
            if (we) busy[wr_addr] <= 1'b0;
            // Reservation is applied after the write so a new producer keeps the register busy
            if (rsv_en && !rsv_special) busy[rsv_addr] <= 1'b1;
          end
        end
      endcase
    end
  end

  // Storage has no reset; the sweep is what zeroes it
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_CLEAR) begin
        mem[sweep_cnt] <= '0;
      end else if (!clear_req && wr_legal) begin
        mem[wr_addr] <= wd;
      end
    end
  end

  always_comb begin : rd_mux
    logic [ADDR_W-1:0] ra;
    ra      = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      if (ready) begin
        if (SPECIAL_EN && (ra == SPEC_ADDR)) begin
          rd_data[k*DATA_W +: DATA_W] = ext_special;
        end else if (wr_legal && (ra == wr_addr)) begin
          rd_data[k*DATA_W +: DATA_W] = wd;
        end else begin
          rd_data[k*DATA_W +: DATA_W] = mem[ra];
          rd_busy[k]                  = busy[ra];
        end
      end
    end
  end

endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised successor of the scalar register file: configurable data width, register count, and number of read ports.
- Keeps the hardwired "special" register that reads from an external value (e.g. PC).
- Adds a hardware clear sweep after reset, write-to-read bypass, a per-register busy scoreboard for pipeline hazard detection, and write-error reporting.
- Sits between decode (reads, reservations) and write-back (writes) in the scalar pipeline.

Parameters:
DATA_W, 16, register width in bits
NUM_REGS, 8, number of registers (power of two, >=2)
ADDR_W, $clog2(NUM_REGS), register index width
NUM_RD, 2, number of independent read ports (1..4)
SPECIAL_EN, 1, 1 = register SPECIAL_IDX reads ext_special instead of storage
SPECIAL_IDX, NUM_REGS-1, index of the hardwired register

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
clear_req  in  1  one-cycle pulse: restart the clear sweep
ready  out  1  1 = sweep done, file usable
we  in  1  write enable
wr_addr  in  ADDR_W  write destination register
wd  in  DATA_W  write data
ext_special  in  DATA_W  value returned for SPECIAL_IDX reads
rsv_en  in  1  reserve destination (mark busy)
rsv_addr  in  ADDR_W  register to reserve
rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  1 = register addressed on port k is reserved and not yet written
wr_err  out  1  registered one-cycle pulse on an illegal write

Behaviour:
- State machine: CLEAR, READY.
- Reset (rst_n=0 at a rising edge): state=CLEAR, sweep counter=0, all busy bits=0, wr_err=0, ready=0. Storage is not cleared by reset directly; the sweep clears it.
- CLEAR state:
  - Each cycle writes 0 to register[counter] and increments the counter.
  - After writing NUM_REGS-1, the next state is READY. The sweep takes exactly NUM_REGS cycles, so ready rises NUM_REGS cycles after rst_n deasserts.
  - we is ignored during CLEAR, and wr_err pulses the next cycle if we=1.
  - rsv_en is ignored.
  - rd_data is 0 on all ports; rd_busy is 0.
- clear_req=1 in READY: next state is CLEAR with counter=0, and all busy bits are cleared. clear_req in CLEAR restarts the counter at 0.
- Write, READY state: if we=1 and wr_addr!=SPECIAL_IDX (or SPECIAL_EN=0), then register[wr_addr]<=wd at the rising edge and busy[wr_addr]<=0.
- Write to SPECIAL_IDX with SPECIAL_EN=1: storage is unchanged, busy is cleared, and wr_err pulses the next cycle.
- Read (combinational, every port independent), with this priority:
  1. Not ready: 0.
  2. SPECIAL_EN and addr==SPECIAL_IDX: ext_special.
  3. we and addr==wr_addr (legal write): wd (bypass).
  4. Otherwise: register[addr].
- Multiple ports may read the same address.
- rd_busy[k]: busy[addr_k], except 0 when the same-cycle legal write targets addr_k (bypass resolves the hazard). Always 0 for SPECIAL_IDX when SPECIAL_EN=1.
- Reservation, READY state: rsv_en sets busy[rsv_addr] at the edge. rsv_en on SPECIAL_IDX (SPECIAL_EN=1) is ignored.
- Simultaneous reserve and write to the same register: the write updates data, and busy ends as 1 (the new producer wins).
- Reset mid-sweep or mid-operation: takes effect at the next edge and restarts the sweep at 0.
- Latency: write visible to reads in the same cycle via bypass, from storage from the next cycle. Busy bit visible the cycle after rsv_en.
- No arithmetic. Address compares are exact ADDR_W-bit equality.

Test Plan:
- Reset, sweep (defaults): hold rst_n=0 for 2 cycles, release -> ready=0 for 8 cycles, then ready=1 and all ports read 0x0000 from r0..r6.
- Write/bypass: we=1, wr_addr=3, wd=0xBEEF, rd_addr port0=3 in the same cycle -> rd_data0=0xBEEF combinationally; next cycle with we=0 -> still 0xBEEF.
- Special register: ext_special=0x1234, port1 reads 7 -> 0x1234. Write 0xAAAA to 7 -> wr_err=1 for exactly one cycle, and the read still returns 0x1234.
- Scoreboard:
  - rsv_en addr 2 -> next cycle rd_busy=1 for a port reading 2.
  - A write to 2 with port reading 2 in the same cycle -> rd_busy=0 and data bypassed.
  - Following cycle -> busy=0.
  - Simultaneous rsv_en and we to 5 -> data updated, busy=1 afterwards.
- Clear mid-operation: r4=0x00FF, pulse clear_req -> ready=0 for 8 cycles, writes during the sweep assert wr_err, final r4=0x0000. Reset asserted at sweep count 3 -> sweep restarts, total 8 cycles from release.
- Parameter sweep: DATA_W=32, NUM_REGS=16, NUM_RD=3, SPECIAL_EN=0 -> sweep takes 16 cycles, r15 is writable/readable (0xDEADBEEF), wr_err never asserts on legal writes.
